// File: rtl/counter_pkg.sv
// Shared constants and mode decoding for the programmable counter.
// Reserved mode encodings fall back to free-running behaviour.
package counter_pkg;

   localparam logic [1:0] MODE_FREE    = 2'b00;
   localparam logic [1:0] MODE_MODULO  = 2'b01;
   localparam logic [1:0] MODE_ONESHOT = 2'b10;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   typedef enum logic [1:0] {
      STEP_FREE,
      STEP_MODULO,
      STEP_ONESHOT
   } step_kind_e;

   function automatic step_kind_e decode_mode(input logic [1:0] mode);
      step_kind_e kind;
      case (mode)
         MODE_MODULO:  kind = STEP_MODULO;
         MODE_ONESHOT: kind = STEP_ONESHOT;
         default:      kind = STEP_FREE;
      endcase
      return kind;
   endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Prescaler producing a step tick every (presc+1) enabled clocks.
// The >= compare lets presc be lowered mid-run without stalling.
module counter_prescaler #(
   parameter int PRESC_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               sync_clr,
   input  logic [PRESC_W-1:0] presc,
   output logic               tick
);

   logic [PRESC_W-1:0] pcnt_q;
   logic [PRESC_W-1:0] pcnt_d;

   assign tick = en && (pcnt_q >= presc);

   always_comb begin
      pcnt_d = pcnt_q;
      if (sync_clr) begin
         pcnt_d = '0;
      end else if (tick) begin
         pcnt_d = '0;
      end else if (en) begin
         pcnt_d = pcnt_q + PRESC_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
      end
   end

endmodule

// File: rtl/prog_counter.sv
// Loadable up/down counter with prescaler and free-run, modulo and one-shot modes.
// Produces a registered one-cycle terminal-count pulse and a one-shot done level.
module prog_counter
   import counter_pkg::*;
#(
   parameter int WIDTH   = 26,
   parameter int PRESC_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               clr,
   input  logic               load,
   input  logic [WIDTH-1:0]   load_val,
   input  logic               dir,
   input  logic [1:0]         mode,
   input  logic [WIDTH-1:0]   limit,
   input  logic [PRESC_W-1:0] presc,
   output logic [WIDTH-1:0]   out,
   output logic               tc,
   output logic               done
);

   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] out_d;
   logic             tc_q;
   logic             tc_d;
   logic             done_q;
   logic             done_d;
   logic             tick;
   logic [WIDTH-1:0] inc_val;
   logic [WIDTH-1:0] dec_val;

   counter_prescaler #(
      .PRESC_W (PRESC_W)
   ) u_prescaler (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .sync_clr (clr | load),
      .presc    (presc),
      .tick     (tick)
   );

   assign inc_val = out_q + WIDTH'(1);
   assign dec_val = out_q - WIDTH'(1);

   // clr beats load beats a step; tc defaults low so it can only last one cycle
   always_comb begin
      out_d  = out_q;
      tc_d   = 1'b0;
      done_d = done_q;
      if (clr) begin
         out_d  = '0;
         done_d = 1'b0;
      end else if (load) begin
         out_d  = load_val;
         done_d = 1'b0;
      end else if (tick) begin
         case (decode_mode(mode))
            STEP_MODULO: begin
               if (dir == DIR_UP) begin
                  if (out_q >= limit) begin
                     out_d = '0;
                     tc_d  = 1'b1;
                  end else begin
                     out_d = inc_val;
                  end
               end else begin
                  if (out_q == '0) begin
                     out_d = limit;
                     tc_d  = 1'b1;
                  end else begin
                     out_d = dec_val;
                  end
               end
            end
            STEP_ONESHOT: begin
               if (!done_q) begin
                  if (dir == DIR_UP) begin
                     if ((out_q >= limit) || (inc_val == limit)) begin
                        out_d  = limit;
                        done_d = 1'b1;
                        tc_d   = 1'b1;
                     end else begin
                        out_d = inc_val;
                     end
                  end else begin
                     if ((out_q == '0) || (dec_val == '0)) begin
                        out_d  = '0;
                        done_d = 1'b1;
                        tc_d   = 1'b1;
                     end else begin
                        out_d = dec_val;
                     end
                  end
               end
            end
            default: begin
               if (dir == DIR_UP) begin
                  out_d = inc_val;
                  tc_d  = (out_q == '1);
               end else begin
                  out_d = dec_val;
                  tc_d  = (out_q == '0);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q  <= '0;
         tc_q   <= 1'b0;
         done_q <= 1'b0;
      end else begin
         out_q  <= out_d;
         tc_q   <= tc_d;
         done_q <= done_d;
      end
   end

   assign out  = out_q;
   assign tc   = tc_q;
   assign done = done_q;

endmodule
